midi_parser: RTL and testbench

- Converts the serial MIDI byte stream from the UART receiver into decoded MIDI messages.
- Sits directly upstream of gen_pulse and drives its midi_rdy/midi_cmd/midi_ch_sysn/midi_data0/midi_data1 inputs.
- Handles running status, interleaved real-time bytes, and SysEx skipping.
- Emits exactly one single-cycle midi_rdy pulse per complete message.

---
 rtl/midi_parser_pkg.sv | 31 +++
 rtl/midi_status_decode.sv | 39 +++
 rtl/midi_parser.sv | 180 ++++++++++++++++++
 tb/tb_midi_parser.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_parser_pkg.sv
// Shared MIDI command codes, parser state encodings and the status-decode record.
package midi_parser_pkg;

    localparam int unsigned MIDI_CMD_SIZE = 4;

    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NONE       = 4'd0;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF   = 4'd1;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON    = 4'd2;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_AFTERTOUCH = 4'd3;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CC         = 4'd4;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PATCH_CHG  = 4'd5;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CHAN_PRESS = 4'd6;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH_BEND = 4'd7;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYS_COMMON = 4'd8;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYS_RT     = 4'd9;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYSEX_END  = 4'd10;

    // Parser states
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWaitD0 = 2'd1;
    localparam logic [1:0] StWaitD1 = 2'd2;
    localparam logic [1:0] StSysex  = 2'd3;

    typedef struct packed {
        logic [MIDI_CMD_SIZE-1:0] cmd;
        logic [1:0]               n_data;     // data bytes that follow this status
        logic                     is_rt;      // F8-FF
        logic                     clears_rs;  // F0-F7
    } status_info_t;

endpackage

// File: rtl/midi_status_decode.sv
// Combinational status-byte classifier: command code, data-byte count and flags.
module midi_status_decode
    import midi_parser_pkg::*;
(
    input  logic [7:0]   status,
    output status_info_t info
);

    // Table lookup on the status byte; non-status bytes decode to NONE
    always_comb begin
        info           = '0;
        info.cmd       = MIDI_CMD_NONE;
        case (status[7:4])
            4'h8: begin info.cmd = MIDI_CMD_NOTE_OFF;   info.n_data = 2'd2; end
            4'h9: begin info.cmd = MIDI_CMD_NOTE_ON;    info.n_data = 2'd2; end
            4'hA: begin info.cmd = MIDI_CMD_AFTERTOUCH; info.n_data = 2'd2; end
            4'hB: begin info.cmd = MIDI_CMD_CC;         info.n_data = 2'd2; end
            4'hC: begin info.cmd = MIDI_CMD_PATCH_CHG;  info.n_data = 2'd1; end
            4'hD: begin info.cmd = MIDI_CMD_CHAN_PRESS; info.n_data = 2'd1; end
            4'hE: begin info.cmd = MIDI_CMD_PITCH_BEND; info.n_data = 2'd2; end
            4'hF: begin
                info.clears_rs = ~status[3];
                case (status[3:0])
                    4'h0:             info.cmd = MIDI_CMD_NONE;  // SysEx start emits nothing
                    4'h1, 4'h3: begin info.cmd = MIDI_CMD_SYS_COMMON; info.n_data = 2'd1; end
                    4'h2:       begin info.cmd = MIDI_CMD_SYS_COMMON; info.n_data = 2'd2; end
                    4'h4, 4'h5, 4'h6: info.cmd = MIDI_CMD_SYS_COMMON;
                    4'h7:             info.cmd = MIDI_CMD_SYSEX_END;
                    default: begin
                        info.cmd   = MIDI_CMD_SYS_RT;
                        info.is_rt = 1'b1;
                    end
                endcase
            end
            default: info.cmd = MIDI_CMD_NONE;
        endcase
    end

endmodule

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: running status, interleaved real-time bytes, SysEx skipping.
module midi_parser
    import midi_parser_pkg::*;
#(
    parameter bit NOTE_ON_VEL0_AS_OFF = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uart_rdy,
    input  logic [7:0]               uart_data,
    output logic                     midi_rdy,
    output logic [MIDI_CMD_SIZE-1:0] midi_cmd,
    output logic [3:0]               midi_ch_sysn,
    output logic [6:0]               midi_data0,
    output logic [6:0]               midi_data1,
    output logic                     midi_err
);

    status_info_t info;

    midi_status_decode u_decode (
        .status (uart_data),
        .info   (info)
    );

    logic [1:0]               state_q, state_d;
    logic                     rs_valid_q, rs_valid_d;
    logic                     in_msg_q, in_msg_d;   // a message has started but not completed
    logic [MIDI_CMD_SIZE-1:0] cur_cmd_q, cur_cmd_d;
    logic                     cur_two_q, cur_two_d;
    logic [3:0]               cur_ch_q, cur_ch_d;
    logic [6:0]               d0_q, d0_d;
    logic                     rdy_q, rdy_d;
    logic                     err_q, err_d;
    logic [MIDI_CMD_SIZE-1:0] out_cmd_q, out_cmd_d;
    logic [3:0]               out_ch_q, out_ch_d;
    logic [6:0]               out_d0_q, out_d0_d;
    logic [6:0]               out_d1_q, out_d1_d;

    // Next-state and message assembly for the byte presented this cycle
    always_comb begin
        state_d    = state_q;
        rs_valid_d = rs_valid_q;
        in_msg_d   = in_msg_q;
        cur_cmd_d  = cur_cmd_q;
        cur_two_d  = cur_two_q;
        cur_ch_d   = cur_ch_q;
        d0_d       = d0_q;
        rdy_d      = 1'b0;
        err_d      = 1'b0;
        out_cmd_d  = out_cmd_q;
        out_ch_d   = out_ch_q;
        out_d0_d   = out_d0_q;
        out_d1_d   = out_d1_q;

        if (uart_rdy) begin
            if (uart_data[7]) begin
                if (info.is_rt) begin
                    // Real-time bytes leave all sequencing state alone
                    rdy_d     = 1'b1;
                    out_cmd_d = MIDI_CMD_SYS_RT;
                    out_ch_d  = uart_data[3:0];
                    out_d0_d  = '0;
                    out_d1_d  = '0;
                end else if (uart_data == 8'hF7) begin
                    if (state_q == StSysex) begin
                        rdy_d     = 1'b1;
                        out_cmd_d = MIDI_CMD_SYSEX_END;
                        out_ch_d  = uart_data[3:0];
                        out_d0_d  = '0;
                        out_d1_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d    = StIdle;
                    rs_valid_d = 1'b0;
                    in_msg_d   = 1'b0;
                end else begin
                    // Any other status also ends a SysEx silently
                    rs_valid_d = ~info.clears_rs;
                    in_msg_d   = 1'b0;
                    cur_cmd_d  = info.cmd;
                    cur_two_d  = (info.n_data == 2'd2);
                    cur_ch_d   = uart_data[3:0];
                    if (info.n_data != 2'd0) begin
                        state_d  = StWaitD0;
                        in_msg_d = 1'b1;
                        err_d    = in_msg_q;
                    end else if (uart_data == 8'hF0) begin
                        state_d = StSysex;
                        err_d   = in_msg_q;
                    end else begin
                        // F4-F6 carry no data; an interrupted partial is dropped silently
                        state_d   = StIdle;
                        rdy_d     = 1'b1;
                        out_cmd_d = info.cmd;
                        out_ch_d  = uart_data[3:0];
                        out_d0_d  = '0;
                        out_d1_d  = '0;
                    end
                end
            end else begin
                case (state_q)
                    StIdle:  err_d = 1'b1;
                    StSysex: err_d = 1'b0;
                    StWaitD0: begin
                        if (cur_two_q) begin
                            d0_d     = uart_data[6:0];
                            state_d  = StWaitD1;
                            in_msg_d = 1'b1;
                        end else begin
                            rdy_d     = 1'b1;
                            out_cmd_d = cur_cmd_q;
                            out_ch_d  = cur_ch_q;
                            out_d0_d  = uart_data[6:0];
                            out_d1_d  = '0;
                            state_d   = rs_valid_q ? StWaitD0 : StIdle;
                            in_msg_d  = 1'b0;
                        end
                    end
                    StWaitD1: begin
                        rdy_d     = 1'b1;
                        out_cmd_d = cur_cmd_q;
                        if (NOTE_ON_VEL0_AS_OFF && cur_cmd_q == MIDI_CMD_NOTE_ON &&
                            uart_data[6:0] == 7'd0) begin
                            out_cmd_d = MIDI_CMD_NOTE_OFF;
                        end
                        out_ch_d = cur_ch_q;
                        out_d0_d = d0_q;
                        out_d1_d = uart_data[6:0];
                        state_d  = rs_valid_q ? StWaitD0 : StIdle;
                        in_msg_d = 1'b0;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rs_valid_q <= 1'b0;
            in_msg_q   <= 1'b0;
            cur_cmd_q  <= MIDI_CMD_NONE;
            cur_two_q  <= 1'b0;
            cur_ch_q   <= '0;
            d0_q       <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            out_cmd_q  <= MIDI_CMD_NONE;
            out_ch_q   <= '0;
            out_d0_q   <= '0;
            out_d1_q   <= '0;
        end else begin
            state_q    <= state_d;
            rs_valid_q <= rs_valid_d;
            in_msg_q   <= in_msg_d;
            cur_cmd_q  <= cur_cmd_d;
            cur_two_q  <= cur_two_d;
            cur_ch_q   <= cur_ch_d;
            d0_q       <= d0_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            out_cmd_q  <= out_cmd_d;
            out_ch_q   <= out_ch_d;
            out_d0_q   <= out_d0_d;
            out_d1_q   <= out_d1_d;
        end
    end

    assign midi_rdy     = rdy_q;
    assign midi_err     = err_q;
    assign midi_cmd     = out_cmd_q;
    assign midi_ch_sysn = out_ch_q;
    assign midi_data0   = out_d0_q;
    assign midi_data1   = out_d1_q;

endmodule

// File: tb/tb_midi_parser.sv
// Scoreboard bench for midi_parser: directed stream cases plus randomized byte streams.
module tb_midi_parser;
    import midi_parser_pkg::*;

    localparam bit VEL0 = 1'b1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rdy = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       midi_rdy;
    logic [3:0] midi_cmd;
    logic [3:0] midi_ch_sysn;
    logic [6:0] midi_data0;
    logic [6:0] midi_data1;
    logic       midi_err;

    midi_parser #(
        .NOTE_ON_VEL0_AS_OFF (VEL0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rdy     (uart_rdy),
        .uart_data    (uart_data),
        .midi_rdy     (midi_rdy),
        .midi_cmd     (midi_cmd),
        .midi_ch_sysn (midi_ch_sysn),
        .midi_data0   (midi_data0),
        .midi_data1   (midi_data1),
        .midi_err     (midi_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic       err;
        logic [3:0] cmd;
        logic [3:0] ch;
        logic [6:0] d0;
        logic [6:0] d1;
        int         due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [21:0] hold = '0;  // expected held {cmd, ch, d0, d1}

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // ---------------- reference model (message-level view of the stream) ----------------
    bit         m_has;       // a status is in force (running or pending system common)
    logic [7:0] m_status;
    bit         m_sysex;
    bit         m_partial;
    logic [6:0] m_data[$];

    function automatic int n_needed(logic [7:0] s);
        if (s < 8'hF0) return (s[7:4] == 4'hC || s[7:4] == 4'hD) ? 1 : 2;
        if (s == 8'hF2) return 2;
        if (s == 8'hF1 || s == 8'hF3) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] cmd_of(logic [7:0] s);
        if (s < 8'hF0) return s[7:4] - 4'h7;
        return MIDI_CMD_SYS_COMMON;
    endfunction

    function automatic void push_ev(logic e, logic [3:0] c, logic [3:0] ch,
                                    logic [6:0] a, logic [6:0] b);
        exp_t x;
        x.err = e; x.cmd = c; x.ch = ch; x.d0 = a; x.d1 = b; x.due = cyc + 1;
        sb.push_back(x);
    endfunction

    function automatic void model_reset();
        m_has = 0; m_status = 8'h00; m_sysex = 0; m_partial = 0; m_data.delete();
    endfunction

    function automatic void model_byte(logic [7:0] b);
        bit         was_partial;
        logic [3:0] c;
        logic [6:0] d1;
        if (b >= 8'hF8) begin
            push_ev(1'b0, MIDI_CMD_SYS_RT, b[3:0], 7'd0, 7'd0);
        end else if (b == 8'hF7) begin
            if (m_sysex) push_ev(1'b0, MIDI_CMD_SYSEX_END, 4'h7, 7'd0, 7'd0);
            else         push_ev(1'b1, 4'd0, 4'd0, 7'd0, 7'd0);
            m_sysex = 0; m_has = 0; m_partial = 0; m_data.delete();
        end else if (b[7]) begin
            was_partial = m_partial;
            m_sysex = 0; m_partial = 0; m_data.delete();
            if (b == 8'hF0) begin
                m_has = 0; m_sysex = 1;
                if (was_partial) push_ev(1'b1, 4'd0, 4'd0, 7'd0, 7'd0);
            end else if (n_needed(b) == 0) begin
                m_has = 0;
                push_ev(1'b0, MIDI_CMD_SYS_COMMON, b[3:0], 7'd0, 7'd0);
            end else begin
                m_has = 1; m_status = b; m_partial = 1;
                if (was_partial) push_ev(1'b1, 4'd0, 4'd0, 7'd0, 7'd0);
            end
        end else if (m_sysex) begin
            // data inside SysEx is swallowed
        end else if (!m_has) begin
            push_ev(1'b1, 4'd0, 4'd0, 7'd0, 7'd0);
        end else begin
            m_data.push_back(b[6:0]);
            m_partial = 1;
            if (m_data.size() == n_needed(m_status)) begin
                c  = cmd_of(m_status);
                d1 = (m_data.size() == 2) ? m_data[1] : 7'd0;
                if (VEL0 && c == MIDI_CMD_NOTE_ON && d1 == 7'd0) c = MIDI_CMD_NOTE_OFF;
                push_ev(1'b0, c, m_status[3:0], m_data[0], d1);
                m_data.delete();
                m_partial = 0;
                if (m_status >= 8'hF0) m_has = 0;  // system common has no running status
            end
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (midi_rdy || midi_err) begin
                check("strobe_exclusive", 32'(midi_rdy & midi_err), 32'd0);
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_strobe: got rdy=%0b err=%0b cmd=%0d, required none",
                             midi_rdy, midi_err, midi_cmd);
                end else begin
                    mon_e = sb.pop_front();
                    check("strobe_cycle", cyc, mon_e.due);
                    check("strobe_kind", 32'({midi_rdy, midi_err}), 32'({~mon_e.err, mon_e.err}));
                    if (!mon_e.err) begin
                        hold = {mon_e.cmd, mon_e.ch, mon_e.d0, mon_e.d1};
                        check("msg_fields", 32'({midi_cmd, midi_ch_sysn, midi_data0, midi_data1}),
                              32'(hold));
                    end else begin
                        check("fields_hold_err",
                              32'({midi_cmd, midi_ch_sysn, midi_data0, midi_data1}), 32'(hold));
                    end
                end
            end else begin
                check("fields_hold", 32'({midi_cmd, midi_ch_sysn, midi_data0, midi_data1}),
                      32'(hold));
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    mon_e = sb.pop_front();
                    check("missed_strobe", cyc, mon_e.due);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        reset = 1'b1;
        uart_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 32'({midi_rdy, midi_err, midi_cmd, midi_ch_sysn,
                                        midi_data0, midi_data1}), 32'd0);
        end
        model_reset();
        sb.delete();
        hold = '0;
        reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where this byte's strobe is visible
    task automatic send(logic [7:0] b, int gap);
        uart_rdy  = 1'b1;
        uart_data = b;
        model_byte(b);
        @(negedge clk);
        uart_rdy = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    logic [7:0] seq[$];

    task automatic send_seq();
        foreach (seq[i]) send(seq[i], 0);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 10) return 8'h00;
        if (r < 45) return 8'($urandom_range(0, 127));
        if (r < 70) return 8'(8'h80 + $urandom_range(0, 111));
        if (r < 80) return 8'(8'hF8 + $urandom_range(0, 7));
        if (r < 95) return 8'(8'hF0 + $urandom_range(0, 7));
        return 8'hF0;
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        seq = '{8'h90, 8'h32, 8'h30};
        send_seq();
        check("tp1_anchor", 32'({midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1}),
              32'({1'b1, 4'd2, 4'd0, 7'd50, 7'd48}));

        seq = '{8'h93, 8'h3C, 8'h40, 8'h3E, 8'h40, 8'h3C, 8'h00};
        send_seq();
        check("tp2_vel0_anchor", 32'({midi_cmd, midi_ch_sysn, midi_data0, midi_data1}),
              32'({4'd1, 4'd3, 7'd60, 7'd0}));

        seq = '{8'h91, 8'h45, 8'hF8, 8'h50, 8'h46, 8'h50};
        send_seq();
        check("tp3_anchor", 32'({midi_cmd, midi_ch_sysn, midi_data0, midi_data1}),
              32'({4'd2, 4'd1, 7'd70, 7'd80}));

        seq = '{8'hF0, 8'h01, 8'h02, 8'h7F, 8'hF7, 8'hC2, 8'h05};
        send_seq();
        check("tp4_anchor", 32'({midi_cmd, midi_ch_sysn, midi_data0, midi_data1}),
              32'({4'd5, 4'd2, 7'd5, 7'd0}));

        do_reset();
        seq = '{8'h40, 8'hB0, 8'h07, 8'h80, 8'h10, 8'h20};
        send_seq();
        check("tp5_anchor", 32'({midi_cmd, midi_ch_sysn, midi_data0, midi_data1}),
              32'({4'd1, 4'd0, 7'd16, 7'd32}));

        send(8'h90, 0);
        do_reset();
        seq = '{8'h32, 8'h30};
        send_seq();
        check("tp6_no_msg", 32'({midi_cmd, midi_ch_sysn, midi_data0, midi_data1}), 32'd0);

        // System common, stray F7 and SysEx interrupted by a channel status
        seq = '{8'hF2, 8'h11, 8'h22, 8'h33, 8'hF3, 8'h05, 8'hF5, 8'hF7,
                8'hF0, 8'h10, 8'hFE, 8'h95, 8'h20, 8'h21, 8'hF6};
        send_seq();

        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            send(rand_byte(), $urandom_range(0, 2));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
